// File: rtl/nbit_logic_pipe.sv
// Two-stage valid/ready pipeline that applies a bitwise logic operation to two
// N-bit operands. It reports zero and parity flags on the result and keeps a
// saturating count of completed output handshakes.
module nbit_logic_pipe #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] done_count
);

    logic [N-1:0]     op_res;

    logic             s1_v_q, s1_v_d;
    logic [N-1:0]     s1_res_q, s1_res_d;
    logic             s2_v_q, s2_v_d;
    logic [N-1:0]     s2_res_q, s2_res_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_par_q, s2_par_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s1_adv;
    logic             s2_adv;
    logic             out_hs;

    // Bitwise operation selected by op
    always_comb begin
        op_res = '0;
        unique case (op)
            3'd0: op_res = a & b;
            3'd1: op_res = a | b;
            3'd2: op_res = a ^ b;
            3'd3: op_res = ~(a & b);
            3'd4: op_res = ~(a | b);
            3'd5: op_res = ~(a ^ b);
            3'd6: op_res = a & ~b;
            3'd7: op_res = a;
        endcase
    end

    // Stage advance enables; a stage may load when it is empty or the next one moves
    always_comb begin
        s2_adv   = ~s2_v_q | out_ready;
        s1_adv   = ~s1_v_q | s2_adv;
        in_ready = s1_adv;
        out_hs   = s2_v_q & out_ready;
    end

    // Next-state for both stages and the saturating handshake counter
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_res_d  = s1_res_q;
        s2_v_d    = s2_v_q;
        s2_res_d  = s2_res_q;
        s2_zero_d = s2_zero_q;
        s2_par_d  = s2_par_q;
        cnt_d     = cnt_q;

        if (s1_adv) begin
            s1_v_d   = in_valid;
            s1_res_d = op_res;
        end

        if (s2_adv) begin
            s2_v_d    = s1_v_q;
            s2_res_d  = s1_res_q;
            s2_zero_d = (s1_res_q == '0);
            s2_par_d  = ^s1_res_q;
        end

        if (out_hs && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset wins over any handshake in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_res_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_res_q  <= '0;
            s2_zero_q <= 1'b0;
            s2_par_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_res_q  <= s1_res_d;
            s2_v_q    <= s2_v_d;
            s2_res_q  <= s2_res_d;
            s2_zero_q <= s2_zero_d;
            s2_par_q  <= s2_par_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs come straight from the S2 registers
    always_comb begin
        out_valid  = s2_v_q;
        out_data   = s2_res_q;
        out_zero   = s2_zero_q;
        out_parity = s2_par_q;
        done_count = cnt_q;
    end

endmodule

// File: tb/tb_nbit_logic_pipe.sv
// Directed self-checking bench for nbit_logic_pipe: op table, flags,
// backpressure, bubble collapse, mid-stream reset and counter saturation.
module tb_nbit_logic_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_zero;
    logic        out_parity;
    logic [15:0] done_count;

    // Second instance with a narrow counter for saturation
    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_a;
    logic [7:0]  s_b;
    logic [2:0]  s_op;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_data;
    logic        s_out_zero;
    logic        s_out_parity;
    logic [1:0]  s_done_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nbit_logic_pipe #(.N(8), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_parity (out_parity),
        .done_count (done_count)
    );

    nbit_logic_pipe #(.N(8), .CNT_W(2)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .a          (s_a),
        .b          (s_b),
        .op         (s_op),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_data   (s_out_data),
        .out_zero   (s_out_zero),
        .out_parity (s_out_parity),
        .done_count (s_done_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] op_exp [8];
        logic [7:0] bp_vals [4];
        logic [7:0] sat_exp_cnt [5];
        int idx;
        int n_out;
        int seen;
        int n_sat;
        logic hs;

        op_exp = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hC0, 8'hF0};
        bp_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        sat_exp_cnt = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0; s_op = 3'd7;

        // Reset state
        step();
        step();
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", {31'b0, out_valid}, 0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 1);
        check_eq("rst_out_data", {24'b0, out_data}, 0);
        check_eq("rst_out_zero", {31'b0, out_zero}, 0);
        check_eq("rst_out_parity", {31'b0, out_parity}, 0);
        check_eq("rst_done_count", {16'b0, done_count}, 0);

        // All eight ops back to back, one result per cycle
        for (int k = 0; k < 9; k++) begin
            if (k < 8) begin
                in_valid = 1'b1; a = 8'hF0; b = 8'h3C; op = 3'(k);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (k == 0) begin
                check_eq("op_latency", {31'b0, out_valid}, 0);
            end else begin
                check_eq("op_valid", {31'b0, out_valid}, 1);
                check_eq("op_data", {24'b0, out_data}, {24'b0, op_exp[k-1]});
            end
        end
        step();
        check_eq("op_drained", {31'b0, out_valid}, 0);
        check_eq("op_count", {16'b0, done_count}, 8);

        // Flags
        in_valid = 1'b1; a = 8'hAA; b = 8'h55; op = 3'd0;
        step();
        a = 8'h07; b = 8'h00; op = 3'd1;
        step();
        in_valid = 1'b0;
        check_eq("flag0_data", {24'b0, out_data}, 0);
        check_eq("flag0_zero", {31'b0, out_zero}, 1);
        check_eq("flag0_parity", {31'b0, out_parity}, 0);
        step();
        check_eq("flag1_data", {24'b0, out_data}, 8'h07);
        check_eq("flag1_zero", {31'b0, out_zero}, 0);
        check_eq("flag1_parity", {31'b0, out_parity}, 1);
        step();
        check_eq("flag_count", {16'b0, done_count}, 10);

        // Backpressure: four PASS_A items with the output stalled
        out_ready = 1'b0; op = 3'd7; b = 8'h00;
        in_valid = 1'b1; a = bp_vals[0];
        step();
        a = bp_vals[1];
        step();
        a = bp_vals[2];
        #1;
        check_eq("bp_in_ready_low", {31'b0, in_ready}, 0);
        check_eq("bp_head", {24'b0, out_data}, 8'h11);
        step();
        step();
        check_eq("bp_stable_data", {24'b0, out_data}, 8'h11);
        check_eq("bp_stable_valid", {31'b0, out_valid}, 1);
        check_eq("bp_still_blocked", {31'b0, in_ready}, 0);
        idx = 2;
        n_out = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && n_out < 4; cyc++) begin
            #1;
            if (out_valid) begin
                check_eq("bp_order", {24'b0, out_data}, {24'b0, bp_vals[n_out]});
                n_out++;
            end
            if (in_valid && in_ready) idx++;
            step();
            if (idx < 4) a = bp_vals[idx];
            else in_valid = 1'b0;
        end
        check_eq("bp_all_out", n_out, 4);
        #1;
        check_eq("bp_no_dup", {31'b0, out_valid}, 0);

        // Bubble collapse: S2 full and stalled, S1 empty
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'h5A;
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1; a = 8'hA5;
        #1;
        check_eq("bub_in_ready", {31'b0, in_ready}, 1);
        check_eq("bub_s2_valid", {31'b0, out_valid}, 1);
        step();
        in_valid = 1'b0;
        #1;
        check_eq("bub_full", {31'b0, in_ready}, 0);
        check_eq("bub_head", {24'b0, out_data}, 8'h5A);
        out_ready = 1'b1;
        step();
        check_eq("bub_second_v", {31'b0, out_valid}, 1);
        check_eq("bub_second", {24'b0, out_data}, 8'hA5);
        step();
        check_eq("bub_empty", {31'b0, out_valid}, 0);

        // Reset with two items in flight
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'h81;
        step();
        a = 8'h42;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_eq("mrst_out_valid", {31'b0, out_valid}, 0);
        check_eq("mrst_count", {16'b0, done_count}, 0);
        check_eq("mrst_in_ready", {31'b0, in_ready}, 1);
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (out_valid) seen++;
        end
        check_eq("mrst_no_ghost", seen, 0);

        // Saturating counter on the CNT_W=2 instance
        n_sat = 0;
        for (int k = 0; k < 12; k++) begin
            if (k < 5) begin
                s_in_valid = 1'b1; s_a = 8'(k + 1);
            end else begin
                s_in_valid = 1'b0;
            end
            #1;
            hs = s_out_valid;
            if (hs && n_sat < 5) begin
                check_eq("sat_data", {24'b0, s_out_data}, n_sat + 1);
            end
            step();
            if (hs && n_sat < 5) begin
                check_eq("sat_count", {30'b0, s_done_count}, {24'b0, sat_exp_cnt[n_sat]});
                n_sat++;
            end
        end
        check_eq("sat_handshakes", n_sat, 5);
        check_eq("sat_final", {30'b0, s_done_count}, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nbit_logic_pipe.md
NBIT_LOGIC_PIPE -- requirements
Module: nbit_logic_pipe

Interface
REQ-001 SHALL have parameter N, default 8, operand/result width in bits (N >= 1).
REQ-002 SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, upstream presents a, b, op.
REQ-006 SHALL have port in_ready, output, 1, block accepts input this cycle.
REQ-007 SHALL have ports a and b, input, N each, operands.
REQ-008 SHALL have port op, input, 3, operation select (REQ-013).
REQ-009 SHALL have port out_valid, output, 1, out_data/flags hold a valid result.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-011 SHALL have ports out_data, output, N, result; out_zero, output, 1, result == 0; out_parity, output, 1, XOR-reduction of result.
REQ-012 SHALL have port done_count, output, CNT_W, number of completed output handshakes.

Function
REQ-013 op encoding SHALL be bitwise per bit i: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (a & ~b), 7 PASS_A; all 8 codes legal.
REQ-014 Input handshake SHALL occur when in_valid & in_ready; output handshake when out_valid & out_ready.
REQ-015 Pipeline SHALL be two register stages: S1 holds valid bit s1_v and N-bit op result; S2 holds s2_v, result, zero flag, parity flag.
REQ-016 Op result SHALL be computed combinationally from a, b, op and captured into S1 on input handshake.
REQ-017 Zero and parity SHALL be computed from S1 result and captured into S2 when S1 advances.
REQ-018 Advance enables: s2_adv = ~s2_v | out_ready; s1_adv = ~s1_v | s2_adv; in_ready = s1_adv (combinational, no dependence on in_valid).
REQ-019 On s2_adv: S2 loads S1 contents and s2_v <= s1_v; otherwise S2 holds all values.
REQ-020 On s1_adv: S1 loads new result and s1_v <= in_valid; otherwise S1 holds.
REQ-021 out_valid = s2_v; out_data/out_zero/out_parity driven directly from S2 registers.
REQ-022 Latency SHALL be 2 cycles: input handshake at edge t yields out_valid high after edge t+2 with no backpressure.
REQ-023 Throughput SHALL be one result per cycle while out_ready stays high.
REQ-024 While out_valid & ~out_ready, S2 outputs SHALL remain stable; S1 fills if empty, after which in_ready = 0.
REQ-025 Bubble collapse: with S2 full and stalled and S1 empty, in_ready SHALL be 1 and one item SHALL be accepted into S1.
REQ-026 Simultaneous output handshake and input handshake in the same cycle SHALL lose no data and duplicate none.
REQ-027 Results SHALL emerge in acceptance order; no reordering.
REQ-028 done_count SHALL increment by 1 on each output handshake and saturate at 2^CNT_W - 1 (no wrap).
REQ-029 out_data/flags when out_valid = 0 are don't-care except after reset (REQ-031).

Reset
REQ-030 rst high at a rising edge SHALL clear s1_v, s2_v and done_count to 0, overriding all handshakes that cycle.
REQ-031 rst SHALL clear S1 result, S2 result, out_zero and out_parity to 0; out_valid = 0 and in_ready = 1 in the cycle after reset.
REQ-032 Reset mid-operation SHALL discard all in-flight items; none SHALL appear on the output afterward.

Verification
REQ-033 N=8, out_ready=1: a=0xF0, b=0x3C, op=0..7 on consecutive cycles -> out_data 0x30,0xFC,0xCC,0xCF,0x03,0x33,0xC0,0xF0 starting 2 cycles later, one per cycle.
REQ-034 Flags: a=0xAA, b=0x55, op=0 -> out_data 0x00, out_zero=1, out_parity=0; a=0x07, b=0x00, op=1 -> 0x07, zero=0, parity=1.
REQ-035 Backpressure: stream 4 items with out_ready=0 -> after 2 accepts in_ready=0, out_data stable; raise out_ready -> all 4 results emerge in order, none lost or duplicated.
REQ-036 Bubble: S2 full stalled, S1 empty, in_valid=1 -> in_ready=1, item accepted; next cycle in_ready=0.
REQ-037 Reset mid-stream: 2 items in flight, assert rst 1 cycle -> out_valid=0, done_count=0, neither item ever output.
REQ-038 Saturation: CNT_W=2, 5 output handshakes -> done_count reads 1,2,3,3,3.
